// File: rtl/counter_sequencer.sv
// Prescaled up/down run counter with start/stop/hold, one-shot or auto-reload runs.
// All outputs registered; the first step tick lands PRESCALE cycles after RUN is entered.
module counter_sequencer #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 50000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic             dir,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             busy,
    output logic             done
);

    localparam int             PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PMAX = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

    state_t           state, state_nx;
    logic [PW-1:0]    presc, presc_nx;
    logic [WIDTH-1:0] count_nx, lim_q, lim_nx;
    logic [WIDTH-1:0] start_val, end_val, step_val;
    logic             dir_q, dir_nx, rld_q, rld_nx;
    logic             tick_nx, done_nx, busy_nx;

    assign start_val = dir_q ? '0 : lim_q;
    assign end_val   = dir_q ? lim_q : '0;
    assign step_val  = dir_q ? count + ONE : count - ONE;

    always_comb begin
        state_nx = state;
        presc_nx = presc;
        count_nx = count;
        lim_nx   = lim_q;
        dir_nx   = dir_q;
        rld_nx   = rld_q;
        tick_nx  = 1'b0;
        done_nx  = 1'b0;
        busy_nx  = busy;
        if (stop && state != IDLE) begin
            state_nx = IDLE;
            presc_nx = '0;
            count_nx = '0;
            busy_nx  = 1'b0;
        end else if (start && (state == IDLE || state == DONE)) begin
            lim_nx   = limit;
            dir_nx   = dir;
            rld_nx   = auto_reload;
            presc_nx = '0;
            if (limit == '0) begin
                state_nx = DONE;
                count_nx = '0;
                done_nx  = 1'b1;
                busy_nx  = 1'b0;
            end else begin
                state_nx = RUN;
                count_nx = dir ? '0 : limit;
                busy_nx  = 1'b1;
            end
        end else if (state == RUN || state == HOLD) begin
            if (hold) begin
                state_nx = HOLD;
            end else begin
                // Leaving HOLD advances the prescaler in the same cycle, keeping step phase intact.
                state_nx = RUN;
                if (presc == PMAX) begin
                    presc_nx = '0;
                    tick_nx  = 1'b1;
                    if (count == end_val) begin
                        count_nx = start_val;
                    end else begin
                        count_nx = step_val;
                        if (step_val == end_val) begin
                            done_nx = 1'b1;
                            if (!rld_q) begin
                                state_nx = DONE;
                                busy_nx  = 1'b0;
                            end
                        end
                    end
                end else begin
                    presc_nx = presc + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            presc <= '0;
            count <= '0;
            lim_q <= '0;
            dir_q <= 1'b0;
            rld_q <= 1'b0;
            tick  <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            presc <= presc_nx;
            count <= count_nx;
            lim_q <= lim_nx;
            dir_q <= dir_nx;
            rld_q <= rld_nx;
            tick  <= tick_nx;
            done  <= done_nx;
            busy  <= busy_nx;
        end
    end

endmodule
